// File: rtl/frame_sequencer.sv
// Frame sequencer: divides clk into sequencer steps and issues quarter/half-frame
// strobes plus the frame interrupt, restarted by toggle-signalled writes to reg_4017.
module frame_sequencer #(
    parameter int unsigned STEP_DIV = 7457
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reg_4017,
    input  logic       reg_change,
    input  logic       irq_ack,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq,
    output logic [2:0] step
);

    localparam logic [15:0] TC_VALUE = 16'(STEP_DIV - 1);

    logic        sync0_reg;
    logic        sync1_reg;
    logic        load_reg;
    logic        mode_reg;
    logic        inhibit_reg;
    logic [15:0] prescaler_reg;
    logic [15:0] prescaler_next;
    logic [2:0]  step_reg;
    logic [2:0]  step_next;
    logic        tc;
    logic        last_step;
    logic        quarter_next;
    logic        half_next;
    logic        irq_next;
    logic        unused_bits;

    assign unused_bits = ^reg_4017[5:0];
    assign step        = step_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            // Preload the synchroniser so the first post-reset cycle sees no edge
            sync0_reg     <= reg_change;
            sync1_reg     <= reg_change;
            load_reg      <= 1'b0;
            mode_reg      <= 1'b0;
            inhibit_reg   <= 1'b0;
            prescaler_reg <= '0;
            step_reg      <= '0;
            enable_240hz  <= 1'b0;
            enable_120hz  <= 1'b0;
            frame_irq     <= 1'b0;
        end else begin
            sync0_reg     <= reg_change;
            sync1_reg     <= sync0_reg;
            load_reg      <= (sync1_reg != sync0_reg);
            if (load_reg) begin
                mode_reg    <= reg_4017[7];
                inhibit_reg <= reg_4017[6];
            end
            prescaler_reg <= prescaler_next;
            step_reg      <= step_next;
            enable_240hz  <= quarter_next;
            enable_120hz  <= half_next;
            frame_irq     <= irq_next;
        end
    end

    // Next-state logic: a load restarts the sequence and swallows any coincident TC
    always_comb begin
        tc             = (prescaler_reg == TC_VALUE);
        last_step      = mode_reg ? (step_reg >= 3'd4) : (step_reg >= 3'd3);
        prescaler_next = prescaler_reg + 16'd1;
        step_next      = step_reg;
        if (load_reg) begin
            prescaler_next = '0;
            step_next      = '0;
        end else if (tc) begin
            prescaler_next = '0;
            step_next      = last_step ? 3'd0 : step_reg + 3'd1;
        end
    end

    // Output logic: strobes are decoded from the step that is completing
    always_comb begin
        quarter_next = 1'b0;
        half_next    = 1'b0;
        irq_next     = frame_irq;
        if (load_reg) begin
            quarter_next = reg_4017[7];
            half_next    = reg_4017[7];
            if (reg_4017[6] || irq_ack) begin
                irq_next = 1'b0;
            end
        end else begin
            if (tc) begin
                quarter_next = mode_reg ? (step_reg != 3'd3) : 1'b1;
                half_next    = mode_reg ? (step_reg == 3'd1 || step_reg == 3'd4)
                                        : (step_reg == 3'd1 || step_reg == 3'd3);
            end
            // A set event beats a simultaneous acknowledge
            if (tc && !mode_reg && !inhibit_reg && step_reg == 3'd3) begin
                irq_next = 1'b1;
            end else if (irq_ack) begin
                irq_next = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised scoreboard bench for frame_sequencer; the reference model tracks elapsed
// cycles since the last restart and derives step and strobes arithmetically.
module tb_frame_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] reg_4017 = 8'h00;
    logic       reg_change = 1'b0;
    logic       irq_ack = 1'b0;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       frame_irq;
    logic [2:0] step;

    frame_sequencer #(.STEP_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_4017     (reg_4017),
        .reg_change   (reg_change),
        .irq_ack      (irq_ack),
        .enable_240hz (enable_240hz),
        .enable_120hz (enable_120hz),
        .frame_irq    (frame_irq),
        .step         (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       q;
        logic       h;
        logic       irq;
        logic [2:0] st;
        int         edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   pend[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    // Reference model state
    int         m_t = 0;
    bit         m_mode = 0;
    bit         m_inh = 0;
    bit         m_irq = 0;
    logic [7:0] held_val = 8'h00;

    function automatic int seq_len();
        return m_mode ? 5 : 4;
    endfunction

    task automatic chk(input string name, input int edge_no, input logic [2:0] act, input logic [2:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s edge %0d: got %0d expected %0d", name, edge_no, act, expv);
        end
    endtask

    task automatic drive(input bit r, input bit ack, input bit tog, input logic [7:0] val_in);
        exp_t       e;
        bit         apply;
        int         c;
        bit         q;
        bit         h;
        logic [7:0] val;
        val = val_in;
        @(negedge clk);
        if (tog) held_val = val;
        else if (pend.size() != 0) val = held_val;
        rst = r;
        irq_ack = ack;
        reg_4017 = val;
        if (tog) reg_change = ~reg_change;
        edge_cnt++;
        q = 0;
        h = 0;
        if (r) begin
            m_t = 0; m_mode = 0; m_inh = 0; m_irq = 0;
            pend.delete();
        end else begin
            if (tog) pend.push_back(edge_cnt + 2);
            apply = (pend.size() != 0) && (pend[0] == edge_cnt);
            if (apply) begin
                void'(pend.pop_front());
                $display("load applied at edge %0d value %02h", edge_cnt, val);
                m_t = 0;
                m_mode = val[7];
                m_inh = val[6];
                q = m_mode;
                h = m_mode;
                if (m_inh || ack) m_irq = 0;
            end else begin
                m_t++;
                if (m_t % D == 0) begin
                    c = ((m_t / D) - 1) % seq_len();
                    q = m_mode ? (c != 3) : 1'b1;
                    h = m_mode ? (c == 1 || c == 4) : (c == 1 || c == 3);
                    if (!m_mode && !m_inh && c == 3) m_irq = 1;
                    else if (ack) m_irq = 0;
                end else if (ack) begin
                    m_irq = 0;
                end
            end
        end
        e.q = q;
        e.h = h;
        e.irq = m_irq;
        e.st = 3'((m_t / D) % seq_len());
        e.edge_no = edge_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic load(input logic [7:0] val);
        drive(1'b0, 1'b0, 1'b1, val);
    endtask

    function automatic bit set_next();
        int nt;
        nt = m_t + 1;
        if (pend.size() != 0 && pend[0] == edge_cnt + 1) return 0;
        return (nt % D == 0) && !m_mode && !m_inh && (((nt / D) - 1) % 4 == 3);
    endfunction

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached, got timeout expected event", name);
    endtask

    // Monitor: pops one expectation per clock edge and compares
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("enable_240hz", e.edge_no, {2'b0, enable_240hz}, {2'b0, e.q});
                chk("enable_120hz", e.edge_no, {2'b0, enable_120hz}, {2'b0, e.h});
                chk("frame_irq", e.edge_no, {2'b0, frame_irq}, {2'b0, e.irq});
                chk("step", e.edge_no, step, e.st);
                if (e.q || e.h)
                    $display("edge %0d strobe quarter=%b half=%b irq=%b step=%0d",
                             e.edge_no, enable_240hz, enable_120hz, frame_irq, step);
            end
        end
    end

    initial begin
        int i;
        // Reset, then default four-step run with IRQ
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        idle(24);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(3);

        // Five-step mode
        load(8'h80);
        idle(45);

        // Back to four-step; acknowledge coincident with the setting TC
        load(8'h00);
        for (i = 0; i < 100 && !set_next(); i++) idle(1);
        if (!set_next()) timeout("ack_vs_set");
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Inhibit load while IRQ pending
        for (i = 0; i < 100 && !m_irq; i++) idle(1);
        if (!m_irq) timeout("irq_before_inhibit");
        load(8'h40);
        idle(40);

        // Load landing on a TC edge
        load(8'h00);
        idle(5);
        for (i = 0; i < 20 && ((m_t + 3) % D != 0); i++) idle(1);
        load(8'h00);
        idle(8);

        // Reset mid-sequence at step 2, prescaler 2
        for (i = 0; i < 100 && !(m_t % D == 2 && (m_t / D) % 4 == 2); i++) idle(1);
        if (!(m_t % D == 2 && (m_t / D) % 4 == 2)) timeout("rst_at_step2");
        drive(1'b1, 1'b0, 1'b0, 8'hC0);
        idle(12);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            bit r;
            bit tog;
            r = ($urandom_range(0, 299) == 0);
            tog = !r && (pend.size() == 0) && ($urandom_range(0, 39) == 0);
            drive(r, $urandom_range(0, 7) == 0, tog, 8'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter STEP_DIV, default 7457, clk cycles per sequencer step (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port reg_4017  input  8  bit7 = mode (0 four-step, 1 five-step), bit6 = IRQ inhibit, bits5:0 ignored.
REQ-005 SHALL have port reg_change  input  1  toggle signalling a write to reg_4017, asynchronous to clk.
REQ-006 SHALL have port irq_ack  input  1  one-cycle pulse that clears frame_irq.
REQ-007 SHALL have port enable_240hz  output  1  one-cycle quarter-frame strobe to the square and noise channels.
REQ-008 SHALL have port enable_120hz  output  1  one-cycle half-frame strobe to the square and noise channels.
REQ-009 SHALL have port frame_irq  output  1  level frame interrupt flag.
REQ-010 SHALL have port step  output  3  current sequencer step index, for debug.

Function
REQ-011 SHALL synchronise reg_change through two flops (sync0, sync1), then register load = (sync1 != sync0) as a one-cycle pulse.
REQ-012 SHALL capture mode and inhibit from reg_4017 only in a cycle where load=1; reg_4017 changes without a load SHALL have no effect.
REQ-013 SHALL keep a 16-bit prescaler counting 0..STEP_DIV-1 and wrap to 0 at terminal count (TC = prescaler==STEP_DIV-1).
REQ-014 SHALL advance step on TC: 0->1->2->3->0 in four-step mode and 0->1->2->3->4->0 in five-step mode.
REQ-015 SHALL register enable_240hz=1 for exactly one cycle after a TC edge when the completed step is in the quarter set: four-step {0,1,2,3}, five-step {0,1,2,4}.
REQ-016 SHALL register enable_120hz=1 for exactly one cycle after a TC edge when the completed step is in the half set: four-step {1,3}, five-step {1,4}.
REQ-017 SHALL set frame_irq on the TC edge completing step 3 in four-step mode when inhibit=0; five-step mode SHALL never set frame_irq.
REQ-018 SHALL hold frame_irq until irq_ack=1 or a load with inhibit=1; inhibit=1 SHALL also block further setting.
REQ-019 On load, SHALL clear prescaler to 0 and step to 0, and SHALL discard any TC in the same cycle (load has priority, no strobe from the old sequence).
REQ-020 On load with mode=1, SHALL assert enable_240hz and enable_120hz together for one cycle, on the edge following the load cycle.
REQ-021 On load with mode=0, SHALL produce no immediate strobe.
REQ-022 When irq_ack and an IRQ set event occur in the same cycle, set SHALL win and frame_irq SHALL remain 1.
REQ-023 Latency from reg_change toggle to first reset prescaler value SHALL be 3 clk edges: sync0, then sync1+load, then apply.
REQ-024 SHALL keep strobes single-cycle and never assert enable_120hz without enable_240hz in the same cycle.

Reset
REQ-025 rst=1 SHALL, on the next edge, set prescaler=0, step=0, mode=0, inhibit=0, frame_irq=0, enable_240hz=0, enable_120hz=0, load=0.
REQ-026 rst=1 SHALL load sync0 and sync1 with the current reg_change value, so no spurious load follows reset.
REQ-027 rst mid-sequence SHALL abort the sequence with no strobe in the cycle after reset; counting SHALL resume from step 0 when rst=0.
REQ-028 rst SHALL take priority over load, TC and irq_ack.

Verification
REQ-029 Default mode, STEP_DIV=4, after reset -> enable_240hz pulses every 4 cycles; enable_120hz on 2nd and 4th pulses; frame_irq rises with the 4th pulse.
REQ-030 reg_4017=0x80, reg_change toggled -> both strobes high together 3 edges later; then quarter at steps 0,1,2,4 and half at 1,4 (20-cycle frame); frame_irq stays 0.
REQ-031 frame_irq=1, then irq_ack pulse -> frame_irq=0 next edge; irq_ack coincident with step-3 TC -> frame_irq stays 1.
REQ-032 reg_4017=0x40 load while frame_irq=1 -> frame_irq cleared and never set on later step-3 completions.
REQ-033 reg_change toggle timed so load coincides with TC -> no strobe from the old step; prescaler=0, step=0 next edge.
REQ-034 rst asserted for 1 cycle at step 2, prescaler=2 -> all outputs 0, step=0; first strobe 4 cycles after rst release; reg_4017 changes without toggle -> no effect.
